// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory bus between the
// instruction-fetch port and the data port of the core. Data is granted by
// default; after STARVE_LIMIT consecutive data grants with a fetch waiting,
// the fetch is forced through. Hung bus transactions are aborted after
// TIMEOUT bus cycles with a one-cycle bus_err pulse.
//
// Handshake: a requester raises its request (inst_ren, or mem_ren/mem_wen)
// and holds it together with address/data while its stall output is high.
// The access has completed in the cycle where the request is high and the
// stall is low. On the bus side, bus_req stays high until the single-cycle
// bus_ack (or the timeout), and bus_ack outside a bus cycle is ignored.
module unified_mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_stall,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        data_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  localparam int               SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]       TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_BUS = 2'd1,
    D_BUS = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_starve_cnt;
  logic [7:0]      r_tmo_cnt;
  logic            r_i_done;
  logic            r_d_done;
  logic [31:0]     r_inst_data;
  logic [31:0]     r_mem_din;
  logic            r_bus_req;
  logic            r_bus_we;
  logic [31:0]     r_bus_addr;
  logic [31:0]     r_bus_wdata;
  logic            r_bus_err;

  logic            w_pend_d;
  logic            w_pend_i;
  logic            w_grant_i;
  logic            w_grant_d;
  logic            w_in_bus;
  logic            w_tmo_hit;
  logic            w_bus_end;
  logic            w_abort;

  assign w_pend_d  = mem_ren | mem_wen;
  assign w_pend_i  = inst_ren;
  assign w_in_bus  = (r_state == I_BUS) || (r_state == D_BUS);
  // The counter starts at 0 in the first bus cycle, so TIMEOUT-1 marks the
  // last cycle bus_req is allowed to stay high.
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
  assign w_bus_end = w_in_bus && (bus_ack || w_tmo_hit);
  assign w_abort   = w_bus_end && !bus_ack;

  // Next-state and grant decision; data wins ties unless the fetch is starving.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pend_i && (!w_pend_d || (r_starve_cnt == STARVE_MAX))) begin
          w_grant_i   = 1'b1;
          w_state_nxt = I_BUS;
        end else if (w_pend_d) begin
          w_grant_d   = 1'b1;
          w_state_nxt = D_BUS;
        end
      end
      I_BUS, D_BUS: begin
        if (bus_ack || w_tmo_hit) w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered bus outputs: loaded on grant, dropped when the transfer ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= w_abort;
      if (w_grant_d) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= mem_wen;
        r_bus_addr  <= mem_addr;
        r_bus_wdata <= mem_dout;
      end else if (w_grant_i) begin
        r_bus_req  <= 1'b1;
        r_bus_we   <= 1'b0;
        r_bus_addr <= inst_addr;
      end else if (w_bus_end) begin
        r_bus_req <= 1'b0;
        r_bus_we  <= 1'b0;
      end
    end
  end

  // Timeout counter runs only while a bus transfer is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_tmo_cnt <= 8'h0;
    else if (w_in_bus && !w_bus_end) r_tmo_cnt <= r_tmo_cnt + 8'd1;
    else                           r_tmo_cnt <= 8'h0;
  end

  // Consecutive data grants while a fetch waits; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d) begin
      if (!w_pend_i)                        r_starve_cnt <= '0;
      else if (r_starve_cnt != STARVE_MAX)  r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Response capture and done flags; an aborted transfer returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_data <= 32'h0;
      r_mem_din   <= 32'h0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
    end else if (w_bus_end) begin
      if (r_state == I_BUS) begin
        r_inst_data <= bus_ack ? bus_rdata : 32'h0;
        r_i_done    <= 1'b1;
      end else begin
        if (!r_bus_we) r_mem_din <= bus_ack ? bus_rdata : 32'h0;
        r_d_done <= 1'b1;
      end
    end else if (r_state == RESP) begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end
  end

  assign inst_stall = inst_ren & ~r_i_done;
  assign data_stall = (mem_ren | mem_wen) & ~r_d_done;
  assign inst_data  = r_inst_data;
  assign mem_din    = r_mem_din;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_err    = r_bus_err;
  assign dbg_state  = r_state;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory bus between the core's instruction-fetch port and data port.
- Sits between the 5-stage core (inst_*/mem_* interfaces) and the memory.
- Serialises accesses, grants data by default, and prevents fetch starvation.
- Stalls each requester until its access completes, and aborts hung bus transactions on timeout.

Parameters:
- STARVE_LIMIT, 3: maximum consecutive data grants while a fetch is pending; the next grant is then forced to fetch.
- TIMEOUT, 255: bus cycles to wait for bus_ack before aborting; 8-bit counter.

Ports:
- clk  in  1  main clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_ren  in  1  fetch request; held stable with inst_addr while inst_stall=1.
- inst_addr  in  32  fetch address.
- inst_data  out  32  fetched word; valid in the cycle inst_ren=1 and inst_stall=0.
- inst_stall  out  1  fetch not yet complete.
- mem_ren  in  1  data read request.
- mem_wen  in  1  data write request (mem_ren and mem_wen never both 1).
- mem_addr  in  32  data address.
- mem_dout  in  32  write data from the core.
- mem_din  out  32  read data to the core; valid when data_stall=0.
- data_stall  out  1  data access not yet complete.
- bus_req  out  1  bus request; registered output.
- bus_we  out  1  write strobe; registered output.
- bus_addr  out  32  bus address; registered output.
- bus_wdata  out  32  bus write data; registered output.
- bus_rdata  in  32  read data; sampled when bus_ack=1.
- bus_ack  in  1  one-cycle completion; may assert in the first cycle bus_req=1.
- bus_err  out  1  one-cycle pulse when a transaction is aborted.

Behaviour:
- Reset (async, rst_n=0), applies immediately, mid-transaction included:
  - state=IDLE, starve_cnt=0, tmo_cnt=0.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_err=0.
  - inst_data=0, mem_din=0.
  - Stall outputs follow their formulas with done flags=0.
- States: IDLE, I_BUS, D_BUS, RESP.
- IDLE:
  - pend_d = mem_ren|mem_wen; pend_i = inst_ren.
  - If pend_d and pend_i, data wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
  - Single pending requester wins; none pending: stay in IDLE.
  - Grant to D: go to D_BUS. Load bus_addr=mem_addr, bus_we=mem_wen, bus_wdata=mem_dout, bus_req=1.
  - Grant to I: go to I_BUS. Load bus_addr=inst_addr, bus_we=0, bus_req=1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a D grant while pend_i=1.
  - Clears on any I grant, or on a D grant while pend_i=0.
- I_BUS / D_BUS:
  - bus_req held; tmo_cnt increments each cycle.
  - On bus_ack: capture bus_rdata into inst_data (I) or mem_din (D, read only; a write leaves mem_din unchanged). Set the owner's done flag, drop bus_req/bus_we, clear tmo_cnt, go to RESP.
  - If tmo_cnt reaches TIMEOUT without ack: same as ack but captured data=32'h0000_0000, and bus_err pulses 1 for one cycle.
- RESP: lasts one cycle; done flag is high; next state is IDLE; done flag clears.
- Stalls (combinational):
  - inst_stall = inst_ren & ~i_done.
  - data_stall = (mem_ren|mem_wen) & ~d_done.
- Latency:
  - Grant cycle t, ack at t+1 gives stall low at t+2, which is the core's sample cycle.
  - A 0-wait access costs 2 stall cycles; next grant is earliest t+3.
- A requester dropping its request while waiting (pipeline flush) is not an error:
  - The in-flight bus transaction still completes.
  - Captured data is discarded by the core.
- bus_ack while in IDLE/RESP is ignored.

Test Plan:
- Fetch only, addr 0x0000_0040, memory acks on the first bus_req cycle with 0x2408_0005 -> bus_req high 1 cycle; inst_stall=1,1 then 0 with inst_data=0x2408_0005 on the third cycle; bus_we=0.
- Simultaneous fetch (0x44) and store (addr 0x100, data 0xCAFE_F00D) -> store granted first with bus_we=1, bus_wdata=0xCAFE_F00D, inst_stall held; the fetch is granted in the IDLE after RESP.
- Data requests held continuously with fetch pending, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I; starve_cnt returns to 0 after each I grant.
- Memory never acks a load from 0x200, TIMEOUT=255 -> bus_req drops after 255 bus cycles; bus_err pulses once; mem_din=0; data_stall falls in RESP.
- rst_n pulled low mid-D_BUS with ack pending -> bus_req=0 immediately (asynchronously); after release state is IDLE and the next request is granted normally.
- Load with 3-cycle ack delay, bus_rdata=0x1234_5678, then a store to the same address -> mem_din=0x1234_5678 after the load; mem_din is unchanged after the store completes.
